// File: rtl/intra_sched_pkg.sv
// Shared types and widths for the intra-16x16 macroblock scheduler.
package intra_sched_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SCORE_W = 64;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned NZ_W    = 32;
  localparam int unsigned WAIT_W  = 32;

  // One-hot frame sequencer states
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_LOAD  = 5'b00010,
    ST_RUN   = 5'b00100,
    ST_WAIT  = 5'b01000,
    ST_FLUSH = 5'b10000
  } sched_state_e;

  // One picker result together with the macroblock it belongs to
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SCORE_W-1:0] score;
    logic [MODE_W-1:0]  mode;
    logic [NZ_W-1:0]    nz;
  } mb_res_t;

endpackage

// File: rtl/intra_res_buf.sv
// Single-entry result holding register drained by a valid/ready handshake.
module intra_res_buf
  import intra_sched_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cap_en,
  input  mb_res_t cap_data,
  input  logic    clr,
  input  logic    ready,
  output logic    valid,
  output mb_res_t data
);

  logic    valid_q, valid_d;
  mb_res_t data_q, data_d;

  // Clear beats capture; capture is never issued while the entry is held
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (cap_en) begin
      valid_d = 1'b1;
      data_d  = cap_data;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/intra16_mb_scheduler.sv
// Frame sequencer: walks macroblocks in raster order, drives loads and picker
// starts, and buffers one result at a time for the entropy stage.
module intra16_mb_scheduler #(
  parameter int unsigned COORD_W = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_start,
  input  logic [COORD_W-1:0]                   mb_w,
  input  logic [COORD_W-1:0]                   mb_h,
  input  logic                                 abort,
  output logic                                 ld_req,
  output logic [COORD_W-1:0]                   ld_x,
  output logic [COORD_W-1:0]                   ld_y,
  input  logic                                 ld_ack,
  output logic                                 pick_start,
  output logic                                 pick_clear,
  output logic [COORD_W-1:0]                   pick_x,
  output logic [COORD_W-1:0]                   pick_y,
  input  logic                                 pick_done,
  input  logic [intra_sched_pkg::SCORE_W-1:0]  pick_score,
  input  logic [intra_sched_pkg::MODE_W-1:0]   pick_mode,
  input  logic [intra_sched_pkg::NZ_W-1:0]     pick_nz,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [COORD_W-1:0]                   res_x,
  output logic [COORD_W-1:0]                   res_y,
  output logic [intra_sched_pkg::SCORE_W-1:0]  res_score,
  output logic [intra_sched_pkg::MODE_W-1:0]   res_mode,
  output logic [intra_sched_pkg::NZ_W-1:0]     res_nz,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [intra_sched_pkg::WAIT_W-1:0]   wait_cycles
);

  import intra_sched_pkg::*;

  sched_state_e        state_q, state_d;
  logic [COORD_W-1:0]  mb_w_q, mb_w_d, mb_h_q, mb_h_d;
  logic [COORD_W-1:0]  mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ld_req_q, ld_req_d;
  logic                pick_start_q, pick_start_d;
  logic                pick_clear_q, pick_clear_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                buf_cap, buf_clr, buf_valid, buf_free;
  logic                last_col, last_row;
  mb_res_t             cap_data, res_data;

  // Buffer can take a new result next cycle if it is empty or draining now
  assign buf_free = !buf_valid || res_ready;
  assign last_col = (mb_x_q == (mb_w_q - COORD_W'(1)));
  assign last_row = (mb_y_q == (mb_h_q - COORD_W'(1)));
  assign cap_data = '{x: mb_x_q, y: mb_y_q, score: pick_score, mode: pick_mode, nz: pick_nz};

  // Next-state, coordinate walk and registered pulse outputs
  always_comb begin
    state_d      = state_q;
    mb_w_d       = mb_w_q;
    mb_h_d       = mb_h_q;
    mb_x_d       = mb_x_q;
    mb_y_d       = mb_y_q;
    wait_d       = wait_q;
    pick_start_d = 1'b0;
    pick_clear_d = 1'b0;
    frame_done_d = 1'b0;
    buf_cap      = 1'b0;
    buf_clr      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      buf_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            mb_w_d       = mb_w;
            mb_h_d       = mb_h;
            mb_x_d       = '0;
            mb_y_d       = '0;
            wait_d       = '0;
            pick_clear_d = 1'b1;
            state_d      = ((mb_w == '0) || (mb_h == '0)) ? ST_FLUSH : ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Skip RUN when the buffer is already free so the start follows the ack directly
          if (ld_ack) begin
            if (buf_free) begin
              pick_start_d = 1'b1;
              state_d      = ST_WAIT;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (buf_free) begin
            pick_start_d = 1'b1;
            state_d      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_q != '1) begin
            wait_d = wait_q + WAIT_W'(1);
          end
          if (pick_done) begin
            buf_cap = 1'b1;
            if (last_col) begin
              mb_x_d = '0;
              mb_y_d = mb_y_q + COORD_W'(1);
            end else begin
              mb_x_d = mb_x_q + COORD_W'(1);
            end
            state_d = (last_col && last_row) ? ST_FLUSH : ST_LOAD;
          end
        end
        ST_FLUSH: begin
          if (buf_free) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ld_req_d = (state_d == ST_LOAD);
    // Busy covers the frame_done cycle so it falls the cycle after the pulse
    busy_d   = (state_d != ST_IDLE) || frame_done_d;
  end

  // State, frame context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mb_w_q       <= '0;
      mb_h_q       <= '0;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
      wait_q       <= '0;
      ld_req_q     <= 1'b0;
      pick_start_q <= 1'b0;
      pick_clear_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mb_w_q       <= mb_w_d;
      mb_h_q       <= mb_h_d;
      mb_x_q       <= mb_x_d;
      mb_y_q       <= mb_y_d;
      wait_q       <= wait_d;
      ld_req_q     <= ld_req_d;
      pick_start_q <= pick_start_d;
      pick_clear_q <= pick_clear_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  intra_res_buf u_res_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (buf_cap),
    .cap_data (cap_data),
    .clr      (buf_clr),
    .ready    (res_ready),
    .valid    (buf_valid),
    .data     (res_data)
  );

  assign ld_req      = ld_req_q;
  assign ld_x        = mb_x_q;
  assign ld_y        = mb_y_q;
  assign pick_start  = pick_start_q;
  assign pick_clear  = pick_clear_q;
  assign pick_x      = mb_x_q;
  assign pick_y      = mb_y_q;
  assign res_valid   = buf_valid;
  assign res_x       = res_data.x;
  assign res_y       = res_data.y;
  assign res_score   = res_data.score;
  assign res_mode    = res_data.mode;
  assign res_nz      = res_data.nz;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign wait_cycles = wait_q;

endmodule

// File: tb/tb_intra16_mb_scheduler.sv
// Randomized bench for intra16_mb_scheduler: a responder model plays the
// loader, picker and downstream sink, and predicts results and timing.
module tb_intra16_mb_scheduler;

  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [CW-1:0] mb_w = '0, mb_h = '0;
  logic          abort = 1'b0;
  logic          ld_req, ld_ack = 1'b0;
  logic [CW-1:0] ld_x, ld_y, pick_x, pick_y, res_x, res_y;
  logic          pick_start, pick_clear, pick_done = 1'b0;
  logic [63:0]   pick_score = '0, res_score;
  logic [1:0]    pick_mode = '0, res_mode;
  logic [31:0]   pick_nz = '0, res_nz, wait_cycles;
  logic          res_valid, res_ready = 1'b0, busy, frame_done;

  typedef struct {
    int          x;
    int          y;
    logic [63:0] score;
    logic [1:0]  mode;
    logic [31:0] nz;
  } exp_t;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  intra16_mb_scheduler #(.COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mb_w(mb_w), .mb_h(mb_h),
    .abort(abort), .ld_req(ld_req), .ld_x(ld_x), .ld_y(ld_y), .ld_ack(ld_ack),
    .pick_start(pick_start), .pick_clear(pick_clear), .pick_x(pick_x), .pick_y(pick_y),
    .pick_done(pick_done), .pick_score(pick_score), .pick_mode(pick_mode), .pick_nz(pick_nz),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_score(res_score), .res_mode(res_mode), .res_nz(res_nz), .busy(busy),
    .frame_done(frame_done), .wait_cycles(wait_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({ld_req, pick_start, pick_clear, busy, frame_done, res_valid}), 64'(0));
    chk({tag, "_xy"}, 64'({ld_x, ld_y, pick_x, pick_y, res_x, res_y}), 64'(0));
    chk({tag, "_score"}, res_score, 64'(0));
    chk({tag, "_mode_nz"}, 64'({res_mode, res_nz}), 64'(0));
    chk({tag, "_wait"}, 64'(wait_cycles), 64'(0));
  endtask

  // One frame of w x h MBs; ready_pct < 0 holds res_ready low for 20 cycles after the first result
  task automatic run_frame(input int w, input int h, input int ack_max, input int done_max,
                           input int ready_pct, input bit inject_fs, input int abort_idx);
    exp_t q[$];
    exp_t e;
    int   total = w * h;
    int   cyc = 0, ld_idx = 0, pk_idx = 0, acc_cnt = 0, ack_cnt = 0, done_cnt = 0;
    int   wsum = 0, ps_cyc = 0, last_acc = -10, n_clear = 0, first_valid = -1;
    bit   ack_armed = 0, done_armed = 0, exp_ps = 0, exp_ps_val = 0, exp_dn = 0;
    bit   last_done = 0, run_wait = 0, prev_free = 1, fin = 0, aborted = 0;

    @(posedge clk); #1;
    frame_start = 1'b1; mb_w = CW'(w); mb_h = CW'(h);
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      frame_start = 1'b0; ld_ack = 1'b0; pick_done = 1'b0; abort = 1'b0;
      mb_w = CW'($urandom); mb_h = CW'($urandom);
      if (cyc == 1) begin
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_clear", 64'(pick_clear), 64'(1));
        chk("start_ldreq", 64'(ld_req), 64'(1));
      end
      if (pick_clear) n_clear++;
      if (inject_fs && cyc == 6) begin
        chk("inject_busy", 64'(busy), 64'(1));
        frame_start = 1'b1; mb_w = CW'(1); mb_h = CW'(1);
      end
      if (ack_armed) chk("ldreq_held", 64'(ld_req), 64'(1));
      if (run_wait && prev_free) chk("ps_resume", 64'(pick_start), 64'(1));
      if (exp_ps) begin
        chk("ps_after_ack", 64'(pick_start), 64'(exp_ps_val));
        chk("ldreq_drop", 64'(ld_req), 64'(0));
        exp_ps = 0;
        if (!pick_start) run_wait = 1;
      end
      if (exp_dn) begin
        chk("valid_after_done", 64'(res_valid), 64'(1));
        chk("ldreq_after_done", 64'(ld_req), 64'(!last_done));
        exp_dn = 0;
      end
      if (frame_done) begin
        chk("fd_timing", 64'(cyc), 64'(last_acc + 1));
        fin = 1;
      end
      if (pick_start) begin
        chk("ps_gated", 64'(prev_free), 64'(1));
        chk("pick_x", 64'(pick_x), 64'(pk_idx % w));
        chk("pick_y", 64'(pick_y), 64'(pk_idx / w));
        run_wait = 0;
        if (pk_idx == abort_idx) begin
          abort = 1'b1; aborted = 1; fin = 1; res_ready = 1'b0;
        end else begin
          done_armed = 1; done_cnt = int'($urandom_range(done_max, 1)); ps_cyc = cyc;
        end
      end
      if (!aborted) begin
        if (done_armed) begin
          if (done_cnt == 0) begin
            e.x = pk_idx % w; e.y = pk_idx / w;
            e.score = {$urandom, $urandom}; e.mode = 2'($urandom); e.nz = $urandom;
            pick_score = e.score; pick_mode = e.mode; pick_nz = e.nz; pick_done = 1'b1;
            q.push_back(e);
            wsum += cyc - ps_cyc + 1;
            pk_idx++; done_armed = 0; exp_dn = 1; last_done = (pk_idx == total);
          end else begin
            done_cnt--;
          end
        end
        if (ld_req) begin
          if (!ack_armed) begin
            chk("ld_in_range", 64'(ld_idx < total), 64'(1));
            chk("ld_x", 64'(ld_x), 64'(ld_idx % w));
            chk("ld_y", 64'(ld_y), 64'(ld_idx / w));
            ack_armed = 1; ack_cnt = int'($urandom_range(ack_max, 0));
          end
          if (ack_cnt == 0) begin
            ld_ack = 1'b1; ack_armed = 0; ld_idx++; exp_ps = 1;
          end else begin
            ack_cnt--;
          end
        end
        if (res_valid && first_valid < 0) first_valid = cyc;
        if (ready_pct < 0) res_ready = (first_valid >= 0) && (cyc >= first_valid + 20);
        else res_ready = (int'($urandom_range(99, 0)) < ready_pct);
        if (res_valid && res_ready) begin
          if (q.size() == 0) begin
            chk("res_unexpected", 64'(1), 64'(0));
          end else begin
            e = q.pop_front();
            chk("res_x", 64'(res_x), 64'(e.x));
            chk("res_y", 64'(res_y), 64'(e.y));
            chk("res_score", res_score, e.score);
            chk("res_mode", 64'(res_mode), 64'(e.mode));
            chk("res_nz", 64'(res_nz), 64'(e.nz));
          end
          acc_cnt++; last_acc = cyc;
        end
        if (exp_ps) exp_ps_val = !res_valid || res_ready;
        prev_free = !res_valid || res_ready;
      end
      if (cyc > 3000) begin
        chk("timeout", 64'(0), 64'(1));
        fin = 1;
      end
    end

    @(posedge clk); #1;
    frame_start = 1'b0; ld_ack = 1'b0; pick_done = 1'b0; abort = 1'b0; res_ready = 1'b0;
    if (aborted) begin
      pick_done = 1'b1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_valid", 64'(res_valid), 64'(0));
      chk("abort_ldreq", 64'(ld_req), 64'(0));
      chk("abort_fd", 64'(frame_done), 64'(0));
      repeat (4) begin
        @(posedge clk); #1;
        pick_done = 1'b0;
        chk("abort_quiet", 64'({busy, res_valid, frame_done, ld_req, pick_start}), 64'(0));
      end
    end else begin
      chk("busy_after_fd", 64'(busy), 64'(0));
      chk("fd_single", 64'(frame_done), 64'(0));
      chk("wait_cycles", 64'(wait_cycles), 64'(wsum));
      chk("clear_count", 64'(n_clear), 64'(1));
      chk("result_count", 64'(acc_cnt), 64'(total));
      chk("load_count", 64'(ld_idx), 64'(total));
      chk("queue_empty", 64'(q.size()), 64'(0));
    end
  endtask

  // Degenerate frame: straight to FLUSH, no loads or starts
  task automatic zero_dim(input int w, input int h);
    @(posedge clk); #1;
    frame_start = 1'b1; mb_w = CW'(w); mb_h = CW'(h);
    @(posedge clk); #1;
    frame_start = 1'b0; mb_w = CW'($urandom); mb_h = CW'($urandom);
    chk("zd_busy", 64'(busy), 64'(1));
    chk("zd_clear", 64'(pick_clear), 64'(1));
    chk("zd_ldreq1", 64'(ld_req), 64'(0));
    chk("zd_fd_early", 64'(frame_done), 64'(0));
    @(posedge clk); #1;
    chk("zd_fd", 64'(frame_done), 64'(1));
    chk("zd_quiet", 64'({ld_req, pick_start}), 64'(0));
    @(posedge clk); #1;
    chk("zd_idle", 64'({busy, frame_done}), 64'(0));
    chk("zd_wait", 64'(wait_cycles), 64'(0));
  endtask

  // Reset asserted while the sequencer is stalled in RUN behind a full buffer
  task automatic reset_in_run();
    int n_ack = 0;
    bit hit = 0;
    @(posedge clk); #1;
    frame_start = 1'b1; mb_w = CW'(3); mb_h = CW'(1); res_ready = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0; ld_ack = 1'b0; pick_done = 1'b0;
      if (n_ack == 2) begin
        chk("rr_no_start", 64'(pick_start), 64'(0));
        chk("rr_valid", 64'(res_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_in_run");
        hit = 1;
      end else begin
        if (ld_req) begin ld_ack = 1'b1; n_ack++; end
        if (pick_start) pick_done = 1'b1;
      end
    end
    if (!hit) chk("rr_timeout", 64'(0), 64'(1));
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("after_rst");
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    run_frame(2, 2, 2, 2, 100, 1'b0, -1);
    run_frame(3, 1, 1, 2, -1, 1'b0, -1);
    zero_dim(0, 5);
    zero_dim(3, 0);
    run_frame(4, 4, 1, 3, 100, 1'b0, 1);
    run_frame(1, 1, 2, 2, 100, 1'b0, -1);
    run_frame(3, 3, 2, 4, 70, 1'b1, -1);
    reset_in_run();
    run_frame(2, 2, 1, 2, 100, 1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      run_frame(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)),
                int'($urandom_range(3, 0)), int'($urandom_range(4, 1)),
                int'($urandom_range(100, 30)), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global bound so a stuck handshake can never hang the run
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
